// File: rtl/peripheral_mpram_ahb3_slave.sv
`default_nettype none
// ============================================================================
// peripheral_mpram_ahb3_slave : AHB3-Lite slave driving a 1R1W RAM port pair
// Revision: 1.0
// ============================================================================

module peripheral_mpram_ahb3_slave #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int MEM_ABITS  = 10
) (
   input  logic                    clk_i,
   input  logic                    rst_i,

   input  logic                    HSEL,
   input  logic [HADDR_SIZE-1:0]   HADDR,
   input  logic [HDATA_SIZE-1:0]   HWDATA,
   output logic [HDATA_SIZE-1:0]   HRDATA,
   input  logic                    HWRITE,
   input  logic [2:0]              HSIZE,
   input  logic [2:0]              HBURST,
   input  logic [3:0]              HPROT,
   input  logic [1:0]              HTRANS,
   input  logic                    HREADY,
   output logic                    HREADYOUT,
   output logic                    HRESP,

   output logic [MEM_ABITS-1:0]    mem_waddr_o,
   output logic [HDATA_SIZE-1:0]   mem_din_o,
   output logic                    mem_we_o,
   output logic [HDATA_SIZE/8-1:0] mem_be_o,
   output logic [MEM_ABITS-1:0]    mem_raddr_o,
   output logic                    mem_re_o,
   input  logic [HDATA_SIZE-1:0]   mem_dout_i
);

   localparam int NB = HDATA_SIZE / 8;
   localparam int B  = $clog2(NB);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_WRITE    = 3'd1,
      ST_READ     = 3'd2,
      ST_RD_STALL = 3'd3,
      ST_ERR1     = 3'd4,
      ST_ERR2     = 3'd5
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic                  accept;
   logic [MEM_ABITS-1:0]  addr_word;
   logic [B-1:0]          addr_off;
   logic [B-1:0]          size_mask;
   logic [NB-1:0]         lane_ones;
   logic [NB-1:0]         be_addr;
   logic                  size_err;
   logic                  misalign;
   logic                  xfer_err;
   logic                  hazard;

   logic [MEM_ABITS-1:0]  waddr_r;
   logic [NB-1:0]         be_r;
   logic [MEM_ABITS-1:0]  raddr_r;

   logic                  unused_bits;

   assign unused_bits = ^{HBURST, HPROT, HADDR};

   assign accept    = HSEL & HREADY & HTRANS[1];
   assign addr_word = HADDR[MEM_ABITS+B-1:B];
   assign addr_off  = HADDR[B-1:0];

   // Lane mask of the transfer size, aligned down to its natural boundary.
   always_comb begin
      size_mask = '0;
      lane_ones = '0;
      for (int i = 0; i < B; i++) begin
         size_mask[i] = (i < int'(HSIZE));
      end
      for (int i = 0; i < NB; i++) begin
         lane_ones[i] = (i < (1 << HSIZE));
      end
      size_err = (int'(HSIZE) > B);
      misalign = |(addr_off & size_mask);
      be_addr  = lane_ones << (addr_off & ~size_mask);
   end

   assign xfer_err = size_err | misalign;

   // The RAM only forwards full-word writes; partial same-word hits must wait.
   assign hazard = (state == ST_WRITE) && (addr_word == waddr_r) && (be_r != '1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= ST_IDLE;
         waddr_r <= '0;
         be_r    <= '0;
         raddr_r <= '0;
      end else begin
         state <= state_nxt;
         if (accept && HWRITE && !xfer_err) begin
            waddr_r <= addr_word;
            be_r    <= be_addr;
         end
         if (accept && !HWRITE && !xfer_err) begin
            raddr_r <= addr_word;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      HREADYOUT   = 1'b1;
      HRESP       = 1'b0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_re_o    = 1'b0;
      mem_raddr_o = addr_word;

      case (state)
         ST_WRITE: begin
            mem_we_o = 1'b1;
            mem_be_o = be_r;
         end
         ST_RD_STALL: begin
            HREADYOUT   = 1'b0;
            mem_re_o    = 1'b1;
            mem_raddr_o = raddr_r;
            state_nxt   = ST_READ;
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_nxt = ST_ERR2;
         end
         ST_ERR2: begin
            HRESP = 1'b1;
         end
         default: begin
         end
      endcase

      // Every state that ends with HREADYOUT high may take a new address phase.
      if (state != ST_RD_STALL && state != ST_ERR1) begin
         state_nxt = ST_IDLE;
         if (accept) begin
            if (xfer_err) begin
               state_nxt = ST_ERR1;
            end else if (HWRITE) begin
               state_nxt = ST_WRITE;
            end else if (hazard) begin
               state_nxt = ST_RD_STALL;
            end else begin
               state_nxt = ST_READ;
               mem_re_o  = 1'b1;
            end
         end
      end
   end

   assign mem_waddr_o = waddr_r;
   assign mem_din_o   = HWDATA;
   assign HRDATA      = (state == ST_READ) ? mem_dout_i : '0;

endmodule

`default_nettype wire
